// File: rtl/hilo_pkg.sv
// Shared types and write-enable encodings for the HI/LO write pipeline.
package hilo_pkg;

    typedef struct packed {
        logic        v;
        logic [1:0]  we;
        logic [63:0] d;
    } hilo_wr_t;

    localparam logic [1:0] HILO_WE_HI   = 2'b10;
    localparam logic [1:0] HILO_WE_LO   = 2'b01;
    localparam logic [1:0] HILO_WE_BOTH = 2'b11;

endpackage

// File: rtl/hilo_fwd_mux.sv
// Per-half forwarding select: youngest in-flight write wins, else architectural value.
module hilo_fwd_mux #(
    parameter int DW = 32
) (
    input  logic          m_hit,
    input  logic [DW-1:0] m_val,
    input  logic          w_hit,
    input  logic [DW-1:0] w_val,
    input  logic [DW-1:0] arch_val,
    output logic [DW-1:0] fwd
);

    always_comb begin
        fwd = arch_val;
        if (m_hit) begin
            fwd = m_val;
        end else if (w_hit) begin
            fwd = w_val;
        end
    end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO architectural registers fed by an in-order EX->MEM->WB write pipeline,
// with combinational forwarding of the youngest pending value back to the ALU.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic [1:0]      ex_hilo_we,
    input  logic [2*DW-1:0] ex_hilo_wdata,
    input  logic            m_stall,
    input  logic            m_flush,
    input  logic            m_except,
    input  logic            w_stall,
    output logic [2*DW-1:0] hilo_fwd,
    output logic [DW-1:0]   hi_o,
    output logic [DW-1:0]   lo_o,
    output logic            w_commit
);

    hilo_wr_t      m_ent_p1;
    hilo_wr_t      w_ent_p2;
    logic [DW-1:0] hi_arch;
    logic [DW-1:0] lo_arch;
    logic          commit_en;

    // EX -> MEM: flush beats stall; a stalled or empty EX leaves a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            m_ent_p1.v  <= 1'b0;
            m_ent_p1.we <= 2'b00;
        end else if (m_flush) begin
            m_ent_p1.v <= 1'b0;
        end else if (!m_stall) begin
            if (ex_stall || !ex_valid) begin
                m_ent_p1.v <= 1'b0;
            end else begin
                m_ent_p1.v  <= |ex_hilo_we;
                m_ent_p1.we <= ex_hilo_we & HILO_WE_BOTH;
                m_ent_p1.d  <= 64'(ex_hilo_wdata);
            end
        end
    end

    // MEM -> WB: a held, flushed or excepting MEM entry must not advance
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ent_p2.v  <= 1'b0;
            w_ent_p2.we <= 2'b00;
        end else if (!w_stall) begin
            if (m_stall || m_flush || m_except) begin
                w_ent_p2.v <= 1'b0;
            end else begin
                w_ent_p2 <= m_ent_p1;
            end
        end
    end

    assign commit_en = w_ent_p2.v && !w_stall;

    // WB -> architectural: each half updates only under its own enable
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_arch <= '0;
            lo_arch <= '0;
        end else if (commit_en) begin
            if (|(w_ent_p2.we & HILO_WE_HI)) hi_arch <= w_ent_p2.d[2*DW-1:DW];
            if (|(w_ent_p2.we & HILO_WE_LO)) lo_arch <= w_ent_p2.d[DW-1:0];
        end
    end

    logic m_hit_hi, m_hit_lo, w_hit_hi, w_hit_lo;

    assign m_hit_hi = m_ent_p1.v && m_ent_p1.we[1] && !m_except;
    assign m_hit_lo = m_ent_p1.v && m_ent_p1.we[0] && !m_except;
    assign w_hit_hi = w_ent_p2.v && w_ent_p2.we[1];
    assign w_hit_lo = w_ent_p2.v && w_ent_p2.we[0];

    hilo_fwd_mux #(.DW(DW)) u_fwd_hi (
        .m_hit    (m_hit_hi),
        .m_val    (m_ent_p1.d[2*DW-1:DW]),
        .w_hit    (w_hit_hi),
        .w_val    (w_ent_p2.d[2*DW-1:DW]),
        .arch_val (hi_arch),
        .fwd      (hilo_fwd[2*DW-1:DW])
    );

    hilo_fwd_mux #(.DW(DW)) u_fwd_lo (
        .m_hit    (m_hit_lo),
        .m_val    (m_ent_p1.d[DW-1:0]),
        .w_hit    (w_hit_lo),
        .w_val    (w_ent_p2.d[DW-1:0]),
        .arch_val (lo_arch),
        .fwd      (hilo_fwd[DW-1:0])
    );

    assign hi_o = hi_arch;
    assign lo_o = lo_arch;

    // A reset cycle suppresses the commit, so the trace strobe follows suit
    assign w_commit = commit_en && !rst;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl: in-flight writes are modelled as a queue of
// tagged records, expected outputs are queued per cycle and checked by a monitor.
module tb_hilo_ctrl;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          ex_valid;
    logic          ex_stall;
    logic [1:0]    ex_hilo_we;
    logic [63:0]   ex_hilo_wdata;
    logic          m_stall;
    logic          m_flush;
    logic          m_except;
    logic          w_stall;
    logic [63:0]   hilo_fwd;
    logic [31:0]   hi_o;
    logic [31:0]   lo_o;
    logic          w_commit;

    hilo_ctrl #(.DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_stall      (ex_stall),
        .ex_hilo_we    (ex_hilo_we),
        .ex_hilo_wdata (ex_hilo_wdata),
        .m_stall       (m_stall),
        .m_flush       (m_flush),
        .m_except      (m_except),
        .w_stall       (w_stall),
        .hilo_fwd      (hilo_fwd),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .w_commit      (w_commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // An in-flight write: stage 1 = sitting in MEM, stage 2 = sitting in WB
    typedef struct {
        int          stage;
        logic [1:0]  we;
        logic [63:0] d;
    } ent_t;

    typedef struct {
        logic [63:0] fwd;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        commit;
    } exp_t;

    ent_t        pipe[$];
    exp_t        exp_q[$];
    logic [31:0] arch_hi = '0;
    logic [31:0] arch_lo = '0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle: drive inputs, predict this cycle's outputs, advance the model
    task automatic step(input logic r, input logic ev, input logic es,
                        input logic [1:0] we, input logic [63:0] d,
                        input logic ms, input logic mf, input logic me, input logic ws);
        exp_t        e;
        ent_t        x;
        ent_t        nxt[$];
        logic [31:0] fh, fl;
        bit          hh, hl;
        rst = r; ex_valid = ev; ex_stall = es; ex_hilo_we = we; ex_hilo_wdata = d;
        m_stall = ms; m_flush = mf; m_except = me; w_stall = ws;

        fh = arch_hi; fl = arch_lo; hh = 0; hl = 0;
        for (int s = 1; s <= 2; s++) begin
            foreach (pipe[i]) begin
                if (pipe[i].stage == s && !(s == 1 && me)) begin
                    if (!hh && pipe[i].we[1]) begin fh = pipe[i].d[63:32]; hh = 1; end
                    if (!hl && pipe[i].we[0]) begin fl = pipe[i].d[31:0];  hl = 1; end
                end
            end
        end
        e.fwd = {fh, fl};
        e.hi = arch_hi;
        e.lo = arch_lo;
        e.commit = 1'b0;
        foreach (pipe[i]) if (pipe[i].stage == 2 && !ws && !r) e.commit = 1'b1;
        exp_q.push_back(e);

        if (r) begin
            pipe.delete();
            arch_hi = '0;
            arch_lo = '0;
        end else begin
            foreach (pipe[i]) begin
                x = pipe[i];
                if (x.stage == 2) begin
                    if (ws) nxt.push_back(x);
                    else begin
                        if (x.we[1]) arch_hi = x.d[63:32];
                        if (x.we[0]) arch_lo = x.d[31:0];
                    end
                end else if (!mf) begin
                    if (ms) nxt.push_back(x);
                    else if (!me) begin
                        x.stage = 2;
                        nxt.push_back(x);
                    end
                end
            end
            if (!mf && !ms && ev && !es && we != 2'b00) begin
                x.stage = 1; x.we = we; x.d = d;
                nxt.push_back(x);
            end
            pipe = nxt;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 64'h0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [1:0] we, input logic [63:0] d);
        step(0, 1, 0, we, d, 0, 0, 0, 0);
    endtask

    // Monitor: compares whatever the DUT presents against the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hilo_fwd", hilo_fwd, e.fwd);
                chk("hi_o", {32'h0, hi_o}, {32'h0, e.hi});
                chk("lo_o", {32'h0, lo_o}, {32'h0, e.lo});
                chk("w_commit", {63'h0, w_commit}, {63'h0, e.commit});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic r, ev, es, ms, mf, me, ws;
        logic [1:0] we;
        rst = 1'b1; ex_valid = 0; ex_stall = 0; ex_hilo_we = 0; ex_hilo_wdata = 0;
        m_stall = 0; m_flush = 0; m_except = 0; w_stall = 0;
        repeat (2) @(negedge clk);

        idle(3);
        wr(2'b11, 64'h0000_0001_FFFF_FFFE);
        idle(4);
        wr(2'b10, 64'hAAAA_AAAA_DEAD_BEEF);
        wr(2'b01, 64'h1234_5678_5555_5555);
        idle(4);
        wr(2'b11, 64'hCAFE_F00D_0BAD_CAFE);
        step(0, 0, 0, 2'b00, 64'h0, 0, 0, 1, 0);
        idle(3);
        wr(2'b11, 64'h1111_2222_3333_4444);
        repeat (3) step(0, 0, 0, 2'b00, 64'h0, 1, 0, 0, 0);
        idle(3);
        wr(2'b01, 64'h9999_9999_0000_1234);
        repeat (10) step(0, 1, 1, 2'b11, 64'h7777_7777_8888_8888, 0, 0, 0, 0);
        idle(2);
        wr(2'b11, 64'h5A5A_5A5A_A5A5_A5A5);
        step(0, 0, 0, 2'b00, 64'h0, 1, 1, 0, 0);
        idle(3);
        wr(2'b11, 64'h0F0F_0F0F_F0F0_F0F0);
        idle(1);
        repeat (2) step(0, 0, 0, 2'b00, 64'h0, 1, 0, 0, 1);
        idle(3);
        wr(2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(1);
        step(1, 0, 0, 2'b00, 64'h0, 0, 0, 0, 0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            ev = ($urandom_range(0, 9) < 8);
            es = ($urandom_range(0, 9) < 2);
            we = 2'($urandom_range(0, 3));
            ws = ($urandom_range(0, 9) == 0);
            ms = ws || ($urandom_range(0, 99) < 15);
            mf = ($urandom_range(0, 99) < 8);
            me = ($urandom_range(0, 99) < 8);
            step(r, ev, es, we, {$urandom, $urandom}, ms, mf, me, ws);
        end

        #3;
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
